// File: rtl/fir_pkg.sv
// Shared constants and the rescale/saturate helper for the FIR output path.
package fir_pkg;

    localparam int FIR_IN_W      = 6;
    localparam int FIR_OUT_W     = 8;
    localparam int DEF_OUT_W     = 6;
    localparam int DEF_SHIFT     = 1;
    localparam int DEF_DECIM     = 5;
    localparam int DEF_DEPTH     = 4;

    // Arithmetic shift (floor) followed by clamp to a signed out_w range.
    function automatic int sat_shift(input int value, input int shift, input int out_w);
        int s;
        int hi;
        int lo;
        s  = value >>> shift;
        hi = (1 << (out_w - 1)) - 1;
        lo = -(1 << (out_w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fir_decim_sink_if.sv
// AXI-Stream style output channel of the decimating sink.
interface fir_decim_sink_if #(
    parameter int W = 6
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fir_sample_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module fir_sample_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = cnt_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately unreset; the top masks the output while empty.
    always_ff @(posedge clk) begin
        if (!clr && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fir_decim_sink.sv
// Decimates the FIR stream, rescales/saturates kept samples and queues them
// toward the output port; a full queue drops samples and raises a sticky flag.
module fir_decim_sink
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DECIM = DEF_DECIM,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [IN_W-1:0] fir_tdata,
    input  logic                   fir_tvalid,
    input  logic                   clr,
    fir_decim_sink_if.master       m_axis,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0]  ph_q, ph_d;
    logic             overflow_q, overflow_d;
    logic             keep;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] sample;
    logic [OUT_W-1:0] fifo_dout;

    assign keep   = fir_tvalid && (ph_q == PH_LAST);
    assign sample = OUT_W'(sat_shift(int'(fir_tdata), SHIFT, OUT_W));
    assign pop    = m_axis.tvalid && m_axis.tready;

    always_comb begin
        ph_d = ph_q;
        if (clr) begin
            ph_d = '0;
        end else if (fir_tvalid) begin
            ph_d = keep ? '0 : ph_q + 1'b1;
        end
    end

    // A keep into a full FIFO is lost unless the consumer frees a slot this cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else if (keep && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            ph_q       <= ph_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sample_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (keep),
        .din   (sample),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = fifo_empty ? '0 : fifo_dout;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_fir_decim_sink.sv
// Bench for fir_decim_sink: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_decim_sink;
    localparam int IN_W  = 8;
    localparam int OUT_W = 6;
    localparam int SHIFT = 1;
    localparam int DECIM = 5;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [IN_W-1:0] fir_tdata = '0;
    logic                   fir_tvalid = 1'b0;
    logic                   clr = 1'b0;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    int checks = 0;
    int failures = 0;

    int mq[$];
    int m_ph = 0;
    bit m_ovf = 1'b0;
    int out_log[$];

    fir_decim_sink_if #(.W(OUT_W)) m_if ();

    fir_decim_sink #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DECIM (DECIM),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .fir_tdata  (fir_tdata),
        .fir_tvalid (fir_tvalid),
        .clr        (clr),
        .m_axis     (m_if.master),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Floor division by 2^SHIFT, then clamp into the signed OUT_W range.
    function automatic int ref_sample(input int v);
        int d;
        int s;
        int hi;
        int lo;
        d  = 1 << SHIFT;
        s  = (v >= 0) ? v / d : -((-v + d - 1) / d);
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  n;
        bit  do_pop;
        bit  do_keep;
        if (!rst_n) begin
            mq.delete();
            m_ph  = 0;
            m_ovf = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_ph  = 0;
            m_ovf = 1'b0;
        end else begin
            n       = mq.size();
            do_pop  = (n > 0) && m_if.tready;
            do_keep = 1'b0;
            if (fir_tvalid) begin
                if (m_ph == DECIM - 1) begin
                    do_keep = 1'b1;
                    m_ph    = 0;
                end else begin
                    m_ph++;
                end
            end
            if (do_pop) mq.delete(0);
            if (do_keep) begin
                if (n < DEPTH || do_pop) mq.push_back(ref_sample(int'(fir_tdata)));
                else m_ovf = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && !clr && m_if.tvalid && m_if.tready)
            out_log.push_back(int'($signed(m_if.tdata)));
    end

    always @(negedge clk) begin
        chk("tvalid", int'(m_if.tvalid), (mq.size() > 0) ? 1 : 0);
        chk("level", int'(level), mq.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tdata", int'($signed(m_if.tdata)), (mq.size() > 0) ? mq[0] : 0);
    end

    task automatic cyc(input bit tv, input logic [7:0] td, input bit tr, input bit cl);
        fir_tvalid = tv;
        fir_tdata  = td;
        m_if.tready = tr;
        clr        = cl;
        @(negedge clk);
    endtask

    task automatic skip4(input bit tr);
        for (int j = 0; j < 4; j++) cyc(1'b1, 8'd0, tr, 1'b0);
    endtask

    initial begin
        int exp_dec[4]  = '{4, 9, 14, 19};
        int sat_in[6]   = '{100, -90, 20, -7, 63, -64};
        int sat_exp[6]  = '{31, -32, 10, -4, 31, -32};
        int gap[9]      = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        int exp_full[4] = '{1, 2, 3, 4};
        int exp_sim[5]  = '{1, 2, 3, 4, 9};

        m_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", int'(m_if.tvalid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_tdata", int'(m_if.tdata), 0);
        rst_n = 1'b1;
        repeat (20) cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk("idle_tvalid", int'(m_if.tvalid), 0);
        chk("idle_level", int'(level), 0);
        chk("idle_tdata", int'(m_if.tdata), 0);

        out_log.delete();
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(2 * i), 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("dec_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("dec_value", (i < out_log.size()) ? out_log[i] : -999, exp_dec[i]);

        for (int k = 0; k < 6; k++) begin
            skip4(1'b1);
            cyc(1'b1, 8'(sat_in[k]), 1'b1, 1'b0);
            chk("sat_tvalid", int'(m_if.tvalid), 1);
            chk("sat_value", int'($signed(m_if.tdata)), sat_exp[k]);
        end

        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(gap[i] != 0, 8'(2 * i), 1'b0, 1'b0);
            if (i == 6) chk("gap_before_keep", int'(level), 0);
            if (i == 7) begin
                chk("gap_keep_level", int'(level), 1);
                chk("gap_keep_value", int'($signed(m_if.tdata)), 7);
            end
        end
        chk("gap_after_level", int'(level), 1);

        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            skip4(1'b0);
            cyc(1'b1, 8'(2 * k), 1'b0, 1'b0);
            if (k == 4) begin
                chk("full_level", int'(level), 4);
                chk("full_no_ovf", int'(overflow), 0);
            end
            if (k == 5) chk("ovf_set", int'(overflow), 1);
            if (k == 6) chk("full_level_after", int'(level), 4);
        end
        out_log.delete();
        repeat (4) cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("drain_count", out_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("drain_value", (i < out_log.size()) ? out_log[i] : -999, exp_full[i]);
        chk("drain_level", int'(level), 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk("ovf_sticky", int'(overflow), 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        chk("ovf_clr", int'(overflow), 0);

        for (int k = 1; k <= 4; k++) begin
            skip4(1'b0);
            cyc(1'b1, 8'(2 * k), 1'b0, 1'b0);
        end
        out_log.delete();
        skip4(1'b0);
        cyc(1'b1, 8'd18, 1'b1, 1'b0);
        chk("simul_level", int'(level), 4);
        chk("simul_no_ovf", int'(overflow), 0);
        repeat (5) cyc(1'b0, 8'd0, 1'b1, 1'b0);
        chk("simul_count", out_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("simul_order", (i < out_log.size()) ? out_log[i] : -999, exp_sim[i]);
        skip4(1'b0);
        cyc(1'b1, 8'd22, 1'b0, 1'b0);
        chk("pre_clr_level", int'(level), 1);
        skip4(1'b0);
        cyc(1'b1, 8'd24, 1'b1, 1'b1);
        chk("clr_level", int'(level), 0);
        chk("clr_tvalid", int'(m_if.tvalid), 0);
        chk("clr_ovf", int'(overflow), 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        chk("clr_tvalid_hold", int'(m_if.tvalid), 0);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
